// File: rtl/decode_issue_if.sv
// Fetch/execute handshake bundle for the decode issue buffer.
// Fetch and execute sit on the master side; decode_issue is the slave.
interface decode_issue_if;
    logic [15:0] if_instr;
    logic        if_valid;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        id_valid;
    logic [15:0] instr_out;
    logic [4:0]  Alu_op;
    logic [1:0]  Op_ext;
    logic        err;
    logic        halted;

    modport master (
        output if_instr, if_valid, flush, ex_ready,
        input  if_ready, id_valid, instr_out, Alu_op, Op_ext, err, halted
    );

    modport slave (
        input  if_instr, if_valid, flush, ex_ready,
        output if_ready, id_valid, instr_out, Alu_op, Op_ext, err, halted
    );
endinterface

// File: rtl/decode_issue.sv
// Decode issue buffer: small FIFO between fetch and execute that presents
// the head opcode fields, flags the illegal opcode and drains/stops on HALT.
module decode_issue #(
    parameter int unsigned DEPTH      = 2,
    parameter logic [4:0]  ILLEGAL_OP = 5'b11010,
    parameter logic [4:0]  HALT_OP    = 5'b00000
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_issue_if.slave bus
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [15:0]   head;
    logic          ready_i;
    logic          valid_i;
    logic          push;
    logic          pop;
    logic          flush_now;

    assign head      = mem[rd_ptr];
    assign ready_i   = (state == RUN) && (count < DEPTH_CNT);
    assign valid_i   = (count != '0) && (state != HALTED);
    assign flush_now = bus.flush && (state != HALTED);
    assign push      = bus.if_valid && ready_i && !flush_now;
    assign pop       = valid_i && bus.ex_ready && !flush_now;

    assign bus.if_ready  = ready_i;
    assign bus.id_valid  = valid_i;
    assign bus.instr_out = valid_i ? head : '0;
    assign bus.Alu_op    = valid_i ? head[15:11] : '0;
    assign bus.Op_ext    = valid_i ? head[1:0] : '0;
    assign bus.err       = valid_i && (head[15:11] == ILLEGAL_OP);
    assign bus.halted    = (state == HALTED);

    // State register for the RUN/DRAIN/HALTED sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state: HALT push enters DRAIN, popping the HALT stops, flush squashes.
    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (push && (bus.if_instr[15:11] == HALT_OP)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (head[15:11] == HALT_OP)) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (flush_now) begin
            state_next = RUN;
        end
    end

    // Pointer and occupancy bookkeeping; flush clears the queue outright.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_now) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.if_instr;
        end
    end
endmodule

// File: doc/decode_issue.md
# decode_issue

Instruction-decode issue buffer between fetch and execute. Accepts 16-bit instructions from fetch over a valid/ready handshake, buffers them in a small FIFO, and presents the opcode fields `Alu_op`/`Op_ext` (plus the raw instruction) to the ALU-control/execute side. It is the producer of the `Alu_op`/`Op_ext` interface that the ALU control decoder consumes. It also handles pipeline flush, illegal-opcode flagging and HALT drain/stop.

## Interface
- `DEPTH`, 2: FIFO entries; power of two, at least 2.
- `ILLEGAL_OP`, 5'b11010: the single undefined primary opcode.
- `HALT_OP`, 5'b00000: opcode of HALT.

- `clk`  in  1  sole clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_instr`  in  16  instruction from fetch.
- `if_valid`  in  1  `if_instr` valid.
- `if_ready`  out  1  block can accept this cycle.
- `flush`  in  1  discard all buffered instructions.
- `ex_ready`  in  1  execute consumes head entry this cycle.
- `id_valid`  out  1  head entry valid.
- `instr_out`  out  16  head instruction.
- `Alu_op`  out  5  head `instr[15:11]`.
- `Op_ext`  out  2  head `instr[1:0]`.
- `err`  out  1  head entry has illegal opcode.
- `halted`  out  1  processor halted.

## Operation
- Push: `if_valid && if_ready` writes `if_instr` at the tail.
- Pop: `id_valid && ex_ready` retires the head.
- `if_ready = (state == RUN) && (count < DEPTH)`.
  - No combinational path from `ex_ready` to `if_ready`.
  - When full, the FIFO does not accept a push even in a cycle where it pops.
- `id_valid = (count != 0) && (state != HALTED)`.
- `instr_out`, `Alu_op`, `Op_ext` come from the head register.
  - They are forced to 0 when `id_valid = 0`.
  - There is no decode logic in the output path.
- `err = id_valid && (head[15:11] == ILLEGAL_OP)`.
  - An illegal instruction is still issued and popped normally.
  - It does not change state.
- States:
  - RUN: normal operation.
    - Pushing an instruction whose opcode is `HALT_OP` moves to DRAIN.
  - DRAIN: `if_ready = 0`.
    - Entries ahead of the HALT keep issuing.
    - Popping the HALT entry moves to HALTED.
  - HALTED: `halted = 1`, `id_valid = 0`, FIFO empty, `if_ready = 0`.
    - Only reset leaves this state.
- Flush:
  - In any state other than HALTED, `flush` empties the FIFO next cycle and sets state to RUN, which squashes a pending HALT.
  - If `flush` coincides with a push or pop, flush wins: the pushed instruction is dropped and no pop is counted.
  - In HALTED, flush is ignored.
- Count arithmetic:
  - Pointers are `log2(DEPTH)` bits wide and wrap modulo `DEPTH`.
  - Count is `log2(DEPTH)+1` bits wide.
  - Simultaneous push and pop leaves count unchanged.

## Timing
- Reset (`rst_n` low at a clock edge):
  - state = RUN, count = 0, pointers = 0.
  - Next-cycle outputs: `if_ready = 1`, `id_valid = 0`, `instr_out`/`Alu_op`/`Op_ext` = 0, `err = 0`, `halted = 0`.
- Reset mid-operation discards all entries and any DRAIN/HALTED state.
- Latency: an instruction pushed at edge N into an empty FIFO is visible with `id_valid = 1` after edge N.
  - One cycle fetch-to-issue.
- Throughput is one instruction per cycle when `ex_ready` stays high.
- `halted` rises the cycle after the HALT entry is popped.
  - `id_valid` falls in the same cycle.
- Outputs are functions of registered state only.

## Test plan
- Streaming:
  - Stimulus: reset, then push 0x4123 (ADDI), 0xD9A5 (ADD, `Op_ext` = 01), 0x6800 with `ex_ready = 1`.
  - Required: the three issue on consecutive cycles with `Alu_op` = 01000 / 11011 / 01101 and `Op_ext` = 11 / 01 / 00; `err = 0`.
- Backpressure:
  - Stimulus: hold `ex_ready = 0` and offer 3 instructions.
  - Required: `if_ready` drops after 2 pushes, the third is held by fetch, and after `ex_ready = 1` all three issue in order.
- Illegal opcode:
  - Stimulus: push 0xD000.
  - Required: `id_valid = 1`, `Alu_op` = 11010, `err = 1` for exactly that entry; the following instruction issues with `err = 0`.
- HALT drain:
  - Stimulus: push 0x4001, then 0x0000, then offer 0x4002.
  - Required: `if_ready = 0` after the HALT is accepted; 0x4001 and 0x0000 issue; `halted = 1` thereafter; 0x4002 is never accepted.
- Flush:
  - Stimulus: with HALT and 1 other entry buffered (DRAIN), assert `flush` while `if_valid = 1`.
  - Required: next cycle `id_valid = 0`, count = 0, state RUN, `if_ready = 1`, `halted` stays 0, and the offered instruction is dropped.
- Reset mid-operation:
  - Stimulus: while in HALTED, assert `rst_n = 0` for one edge.
  - Required: `halted = 0`, `if_ready = 1`, `id_valid = 0`, `Alu_op = 0`.
